image_xy_crop_win: RTL and testbench
====================================

Name: image_xy_crop_win

Overview:
- Second-generation runtime crop for the sensor video path. It sits between the sensor capture front end and the scaler/frame buffer writer.
- Adds over the previous crop:
  - independent X and Y start/end windows;
  - multi-component pixels;
  - power-of-two X/Y decimation;
  - frame-synchronous shadowed configuration with validation;
  - end-of-frame signalling.
- Video timing convention is unchanged: vsync high means frame valid, href high means line valid, de high means pixel valid.

Parameters:
- PIXEL_DATA_WIDTH, 8: bits per colour component.
- CHANNELS, 3: components per pixel. Data bus is CHANNELS*PIXEL_DATA_WIDTH bits.
- H_COUNTER_WIDTH, 12: width of the X position counter and the X config fields.
- V_COUNTER_WIDTH, 12: width of the Y position counter and the Y config fields.

Ports:
- clk  in  1  pixel clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- cfg_x_start  in  H_COUNTER_WIDTH  first kept pixel index.
- cfg_x_end  in  H_COUNTER_WIDTH  exclusive X end.
- cfg_y_start  in  V_COUNTER_WIDTH  first kept line index.
- cfg_y_end  in  V_COUNTER_WIDTH  exclusive Y end.
- cfg_x_decim  in  2  keep every 2^n-th pixel (n=0..3).
- cfg_y_decim  in  2  keep every 2^n-th line.
- cfg_update  in  1  one-cycle pulse; samples all cfg_* inputs.
- cfg_pending  out  1  a validated config is waiting for the next frame start.
- cfg_error  out  1  sticky; the last cfg_update was rejected.
- image_in_vsync  in  1  frame valid.
- image_in_href  in  1  line valid.
- image_in_de  in  1  pixel valid.
- image_in_data  in  CHANNELS*PIXEL_DATA_WIDTH  pixel data.
- image_out_vsync  out  1  frame valid, delayed 1 cycle.
- image_out_href  out  1  cropped line valid.
- image_out_de  out  1  cropped pixel valid.
- image_out_data  out  CHANNELS*PIXEL_DATA_WIDTH  pixel data, delayed 1 cycle.
- frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:

Reset:
- All outputs are 0.
- Active config is the defaults: x_start=0, x_end=all-ones, y_start=0, y_end=all-ones, decim=0.
- Pending and error flags are cleared.
- Reset mid-frame drops the frame immediately. Output resumes at the next vsync rising edge.

Config capture (on cfg_update):
- Valid when x_end>x_start and y_end>y_start. A valid capture loads the pending registers, sets cfg_pending and clears cfg_error.
- Invalid captures leave the pending registers untouched and set cfg_error.
- A new cfg_update while pending overwrites the pending values. Last write wins.

Config apply:
- On vsync rising edge (vsync=1, vsync_r=0), if pending: active <= pending, and cfg_pending clears in the same cycle.
- If cfg_update coincides with the rising edge, the old pending value is applied. The new value becomes pending for the following frame.
- Active config never changes while vsync is high.

Counters:
- xpos clears while href=0. It increments on each de=1 cycle and saturates at all-ones; it never wraps.
- While de=1, xpos is the index of the current pixel.
- ypos clears while vsync=0. It increments on each href falling edge and saturates.

Keep conditions:
- x_keep = xpos in [x_start, x_end) and (xpos-x_start)[x_decim-1:0] == 0.
- y_keep = ypos in [y_start, y_end) and (ypos-y_start)[y_decim-1:0] == 0.
- Subtraction is modulo H/V width. It is only evaluated inside the window.

Outputs (1-cycle latency throughout):
- image_out_vsync = vsync_r; image_out_data = data_r.
- image_out_href = registered(href & y_keep & xpos in [x_start, x_end)).
- image_out_de = image_out_href & de_r & registered x_keep.
- A window larger than the input frame passes only the pixels that exist; there is no padding.

frame_done:
- Pulses high on the cycle after the vsync falling edge, only if at least one image_out_de occurred in that frame.

Optional Feature:
- Macro: IMAGE_CROP_STATS_EN.
- Defined:
  - Adds outputs stat_width (H_COUNTER_WIDTH) and stat_height (V_COUNTER_WIDTH).
  - stat_width is the maximum output pixels per line. stat_height is the number of output lines containing at least one image_out_de.
  - Both are measured over the frame, loaded on the frame_done cycle and held until the next frame_done. Reset value is 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package image_crop_pkg holds:
  - DECIM_W=2;
  - typedef crop_cfg_t (x_start, x_end, y_start, y_end, x_decim, y_decim), parametrised by the counter widths through package constants;
  - CROP_CFG_DEFAULT.
- Sub-module crop_cfg_shadow does validation, the pending register, cfg_pending/cfg_error, and apply-on-frame-start. Its output is the active crop_cfg_t.
- The top level holds the counters, keep logic and output pipeline.

Test Plan:
1. Reset, 8x6 frame (all pixels de=1), default config -> output frame equals input (except pixel index 4095); 1-cycle latency; frame_done once.
2. cfg x=[2,6), y=[1,4) applied between frames -> 3 lines of 4 pixels each; ypos 0 and 4-5 produce no href; data equals input pixels 2..5.
3. cfg_x_decim=1, cfg_y_decim=1, window x=[1,7), y=[0,6) -> pixels 1,3,5 on lines 0,2,4; href high over x 1..6, de only on odd-index pixels.
4. cfg_update x_start=5, x_end=5 -> cfg_error=1, cfg_pending unchanged, active window unchanged; next valid update -> cfg_error=0.
5. cfg_update asserted mid-frame and on a vsync rising edge -> current frame is unaffected; mid-frame value applied at the next frame; edge-coincident value applied one frame later.
6. rst_n pulled low mid-line -> all outputs 0 asynchronously; after release, no output until the next vsync rise; window back to default; with IMAGE_CROP_STATS_EN, a case 2 frame gives stat_width=4, stat_height=3.

Source files
------------

// File: rtl/image_crop_pkg.sv
// Shared types and constants for the image_xy_crop_win crop block.
// Config struct widths follow the package counter widths.
package image_crop_pkg;

  localparam int H_W     = 12;
  localparam int V_W     = 12;
  localparam int DECIM_W = 2;

  typedef struct packed {
    logic [H_W-1:0]     x_start;
    logic [H_W-1:0]     x_end;
    logic [V_W-1:0]     y_start;
    logic [V_W-1:0]     y_end;
    logic [DECIM_W-1:0] x_decim;
    logic [DECIM_W-1:0] y_decim;
  } crop_cfg_t;

  localparam crop_cfg_t CROP_CFG_DEFAULT = '{
    x_start: '0,
    x_end:   '1,
    y_start: '0,
    y_end:   '1,
    x_decim: '0,
    y_decim: '0
  };

  // Offset from window start is a multiple of 2^n (n <= 3).
  function automatic logic decim_hit(
    input logic [3:0]         low,
    input logic [DECIM_W-1:0] n
  );
    logic [3:0] mask;
    mask = (4'd1 << n) - 4'd1;
    return (low & mask) == 4'd0;
  endfunction

endpackage

// File: rtl/image_xy_crop_win_cfg.sv
// crop_cfg_shadow: validates cfg writes, holds the pending copy and
// moves it to the active copy at frame start.
module crop_cfg_shadow
  import image_crop_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  crop_cfg_t cfg_i,
  input  logic      cfg_update_i,
  input  logic      frame_start_i,
  output crop_cfg_t active_o,
  output logic      cfg_pending_o,
  output logic      cfg_error_o
);

  crop_cfg_t pend_q, pend_d;
  crop_cfg_t act_q, act_d;
  logic      pnd_q, pnd_d;
  logic      err_q, err_d;
  logic      ok;

  always_comb begin
    ok = (cfg_i.x_end > cfg_i.x_start) &&
         (cfg_i.y_end > cfg_i.y_start);
    pend_d = pend_q;
    act_d  = act_q;
    pnd_d  = pnd_q;
    err_d  = err_q;
    if (frame_start_i && pnd_q) begin
      act_d = pend_q;
      pnd_d = 1'b0;
    end
    // A write on the apply cycle queues for the following frame.
    if (cfg_update_i) begin
      if (ok) begin
        pend_d = cfg_i;
        pnd_d  = 1'b1;
        err_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= CROP_CFG_DEFAULT;
      act_q  <= CROP_CFG_DEFAULT;
      pnd_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      err_q  <= err_d;
    end
  end

  assign active_o      = act_q;
  assign cfg_pending_o = pnd_q;
  assign cfg_error_o   = err_q;

endmodule

// File: rtl/image_xy_crop_win.sv
// Runtime X/Y crop with decimation and shadowed config.
// Optional IMAGE_CROP_STATS_EN adds per-frame output size stats.
module image_xy_crop_win
  import image_crop_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int CHANNELS         = 3,
  parameter int H_COUNTER_WIDTH  = H_W,
  parameter int V_COUNTER_WIDTH  = V_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [H_COUNTER_WIDTH-1:0]         cfg_x_start,
  input  logic [H_COUNTER_WIDTH-1:0]         cfg_x_end,
  input  logic [V_COUNTER_WIDTH-1:0]         cfg_y_start,
  input  logic [V_COUNTER_WIDTH-1:0]         cfg_y_end,
  input  logic [DECIM_W-1:0]                 cfg_x_decim,
  input  logic [DECIM_W-1:0]                 cfg_y_decim,
  input  logic                               cfg_update,
  output logic                               cfg_pending,
  output logic                               cfg_error,
  input  logic                               image_in_vsync,
  input  logic                               image_in_href,
  input  logic                               image_in_de,
  input  logic [CHANNELS*PIXEL_DATA_WIDTH-1:0] image_in_data,
  output logic                               image_out_vsync,
  output logic                               image_out_href,
  output logic                               image_out_de,
  output logic [CHANNELS*PIXEL_DATA_WIDTH-1:0] image_out_data,
  output logic                               frame_done
`ifdef IMAGE_CROP_STATS_EN
  ,
  output logic [H_COUNTER_WIDTH-1:0]         stat_width,
  output logic [V_COUNTER_WIDTH-1:0]         stat_height
`endif
);

  localparam int DW = CHANNELS*PIXEL_DATA_WIDTH;

  crop_cfg_t cfg_in;
  crop_cfg_t act;

  logic          vprev_q, hprev_q, armed_q, seen_q;
  logic [H_W-1:0] xpos_q, xpos_d;
  logic [V_W-1:0] ypos_q, ypos_d;
  logic          vs_q, href_q, de_q, fd_q;
  logic [DW-1:0] data_q;

  logic          rise, fall, armed_nx;
  logic          in_x, x_keep, y_keep;
  logic          href_d, de_d, fd_d;
  logic [3:0]    xlow, ylow;

  assign cfg_in = '{
    x_start: cfg_x_start,
    x_end:   cfg_x_end,
    y_start: cfg_y_start,
    y_end:   cfg_y_end,
    x_decim: cfg_x_decim,
    y_decim: cfg_y_decim
  };

  crop_cfg_shadow u_shadow (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_i         (cfg_in),
    .cfg_update_i  (cfg_update),
    .frame_start_i (rise),
    .active_o      (act),
    .cfg_pending_o (cfg_pending),
    .cfg_error_o   (cfg_error)
  );

  // vprev resets high so a frame already open at reset is not a rise.
  always_comb begin
    rise     = image_in_vsync & ~vprev_q;
    fall     = ~image_in_vsync & vprev_q;
    armed_nx = armed_q | rise;

    xpos_d = xpos_q;
    if (!image_in_href)
      xpos_d = '0;
    else if (image_in_de && xpos_q != '1)
      xpos_d = xpos_q + 1'b1;

    ypos_d = ypos_q;
    if (!image_in_vsync)
      ypos_d = '0;
    else if (hprev_q && !image_in_href && ypos_q != '1)
      ypos_d = ypos_q + 1'b1;

    xlow   = xpos_q[3:0] - act.x_start[3:0];
    ylow   = ypos_q[3:0] - act.y_start[3:0];
    in_x   = (xpos_q >= act.x_start) && (xpos_q < act.x_end);
    x_keep = in_x && decim_hit(xlow, act.x_decim);
    y_keep = (ypos_q >= act.y_start) && (ypos_q < act.y_end) &&
             decim_hit(ylow, act.y_decim);

    href_d = armed_nx & image_in_href & y_keep & in_x;
    de_d   = href_d & image_in_de & x_keep;
    fd_d   = fall & armed_q & (seen_q | de_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vprev_q <= 1'b1;
      hprev_q <= 1'b0;
      armed_q <= 1'b0;
      seen_q  <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vs_q    <= 1'b0;
      href_q  <= 1'b0;
      de_q    <= 1'b0;
      fd_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      vprev_q <= image_in_vsync;
      hprev_q <= image_in_href;
      armed_q <= armed_nx;
      if (rise)
        seen_q <= 1'b0;
      else if (de_q)
        seen_q <= 1'b1;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      vs_q    <= image_in_vsync & armed_nx;
      href_q  <= href_d;
      de_q    <= de_d;
      fd_q    <= fd_d;
      data_q  <= armed_nx ? image_in_data : '0;
    end
  end

  assign image_out_vsync = vs_q;
  assign image_out_href  = href_q;
  assign image_out_de    = de_q;
  assign image_out_data  = data_q;
  assign frame_done      = fd_q;

`ifdef IMAGE_CROP_STATS_EN
  logic [H_W-1:0] cur_w_q, max_w_q, w_now, mx_d;
  logic [V_W-1:0] lines_q, lines_d;
  logic [H_COUNTER_WIDTH-1:0] st_w_q;
  logic [V_COUNTER_WIDTH-1:0] st_h_q;
  logic           line_end;

  // A cropped line closes when the registered href is about to drop.
  always_comb begin
    line_end = href_q & ~href_d;
    w_now    = cur_w_q + H_W'(de_q);
    mx_d     = max_w_q;
    lines_d  = lines_q;
    if (line_end) begin
      if (w_now > max_w_q)
        mx_d = w_now;
      if (w_now != '0)
        lines_d = lines_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_w_q <= '0;
      max_w_q <= '0;
      lines_q <= '0;
      st_w_q  <= '0;
      st_h_q  <= '0;
    end else begin
      if (rise) begin
        cur_w_q <= '0;
        max_w_q <= '0;
        lines_q <= '0;
      end else begin
        cur_w_q <= line_end ? '0 : w_now;
        max_w_q <= mx_d;
        lines_q <= lines_d;
      end
      if (fd_d) begin
        st_w_q <= mx_d;
        st_h_q <= lines_d;
      end
    end
  end

  assign stat_width  = st_w_q;
  assign stat_height = st_h_q;
`endif

endmodule

// File: tb/tb_image_xy_crop_win.sv
// Directed bench for image_xy_crop_win.
// Covers default pass-through, crop, decimation, cfg rules and reset.
module tb_image_xy_crop_win;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   cx0 = '0, cx1 = '0;
  logic [11:0]   cy0 = '0, cy1 = '0;
  logic [1:0]    cxd = '0, cyd = '0;
  logic          cupd = 1'b0;
  logic          cpend, cerr;
  logic          vs = 1'b0, hr = 1'b0, de = 1'b0;
  logic [DW-1:0] din = '0;
  logic          o_vs, o_hr, o_de, fd;
  logic [DW-1:0] o_d;
`ifdef IMAGE_CROP_STATS_EN
  logic [11:0]   st_w, st_h;
`endif

  int total = 0;
  int bad   = 0;

  image_xy_crop_win dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_x_start     (cx0),
    .cfg_x_end       (cx1),
    .cfg_y_start     (cy0),
    .cfg_y_end       (cy1),
    .cfg_x_decim     (cxd),
    .cfg_y_decim     (cyd),
    .cfg_update      (cupd),
    .cfg_pending     (cpend),
    .cfg_error       (cerr),
    .image_in_vsync  (vs),
    .image_in_href   (hr),
    .image_in_de     (de),
    .image_in_data   (din),
    .image_out_vsync (o_vs),
    .image_out_href  (o_hr),
    .image_out_de    (o_de),
    .image_out_data  (o_d),
    .frame_done      (fd)
`ifdef IMAGE_CROP_STATS_EN
    ,
    .stat_width      (st_w),
    .stat_height     (st_h)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int x, input int y);
    return {8'(y), 8'(x), 8'(x * 7 + y * 13)};
  endfunction

  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] exp_q[$];
  int obs_de, obs_href, obs_lines, obs_fd;
  int first_in, first_out, ncyc;
  logic hr_prev = 1'b0;

  task automatic mon_clear();
    obs_q.delete();
    obs_de = 0; obs_href = 0; obs_lines = 0; obs_fd = 0;
    first_in = -1; first_out = -1;
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (de && first_in < 0) first_in = ncyc;
    if (o_de) begin
      obs_q.push_back(o_d);
      obs_de++;
      if (first_out < 0) first_out = ncyc;
    end
    if (o_hr) obs_href++;
    if (o_hr && !hr_prev) obs_lines++;
    hr_prev = o_hr;
    if (fd) obs_fd++;
  end

  function automatic void build_exp(input int xs, input int xe,
    input int ys, input int ye, input int xd, input int yd,
    input int w, input int h);
    exp_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (y >= ys && y < ye && ((y - ys) % (1 << yd)) == 0 &&
            x >= xs && x < xe && ((x - xs) % (1 << xd)) == 0)
          exp_q.push_back(pix(x, y));
  endfunction

  task automatic cmp_data(input string tag);
    int n;
    chk({tag, "_n"}, obs_q.size(), exp_q.size());
    n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_px"}, obs_q[i], exp_q[i]);
  endtask

  task automatic cfg_set(input int xs, input int xe, input int ys,
                         input int ye, input int xd, input int yd);
    cx0 = 12'(xs); cx1 = 12'(xe);
    cy0 = 12'(ys); cy1 = 12'(ye);
    cxd = 2'(xd);  cyd = 2'(yd);
  endtask

  task automatic cfg_pulse();
    @(posedge clk); #1 cupd = 1'b1;
    @(posedge clk); #1 cupd = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit upd_rise,
                           input bit upd_mid, input int rst_line);
    mon_clear();
    @(posedge clk); #1;
    vs = 1'b1; cupd = upd_rise;
    @(posedge clk); #1 cupd = 1'b0;
    repeat (2) @(posedge clk);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        @(posedge clk); #1;
        rst_n = 1'b1;
        hr = 1'b1; de = 1'b1; din = pix(x, y);
        cupd = upd_mid && y == 2 && x == 3;
        if (rst_line == y && x == 3) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_vs", o_vs, 0);
          chk("rst_hr", o_hr, 0);
          chk("rst_de", o_de, 0);
          chk("rst_d", o_d, 0);
          chk("rst_pend", cpend, 0);
        end
      end
      @(posedge clk); #1;
      rst_n = 1'b1; hr = 1'b0; de = 1'b0; din = '0; cupd = 1'b0;
      repeat (3) @(posedge clk);
    end
    @(posedge clk); #1 vs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    mon_clear();
    ncyc = 0;
    #23;
    chk("r_vs", o_vs, 0);
    chk("r_hr", o_hr, 0);
    chk("r_de", o_de, 0);
    chk("r_fd", fd, 0);
    chk("r_pend", cpend, 0);
    chk("r_err", cerr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: default window passes the whole 8x6 frame
    run_frame(8, 6, 0, 0, -1);
    build_exp(0, 4095, 0, 4095, 0, 0, 8, 6);
    chk("t1_de", obs_de, 48);
    chk("t1_lines", obs_lines, 6);
    chk("t1_fd", obs_fd, 1);
    chk("t1_lat", first_out - first_in, 1);
    cmp_data("t1");

    // 2: x=[2,6) y=[1,4)
    cfg_set(2, 6, 1, 4, 0, 0);
    cfg_pulse();
    chk("t2_pend", cpend, 1);
    chk("t2_err", cerr, 0);
    run_frame(8, 6, 0, 0, -1);
    build_exp(2, 6, 1, 4, 0, 0, 8, 6);
    chk("t2_de", obs_de, 12);
    chk("t2_lines", obs_lines, 3);
    chk("t2_href", obs_href, 12);
    chk("t2_fd", obs_fd, 1);
    chk("t2_pend0", cpend, 0);
    cmp_data("t2");
`ifdef IMAGE_CROP_STATS_EN
    chk("t2_sw", st_w, 4);
    chk("t2_sh", st_h, 3);
`endif

    // 3: decimation by 2 in both axes
    cfg_set(1, 7, 0, 6, 1, 1);
    cfg_pulse();
    run_frame(8, 6, 0, 0, -1);
    build_exp(1, 7, 0, 6, 1, 1, 8, 6);
    chk("t3_de", obs_de, 9);
    chk("t3_lines", obs_lines, 3);
    chk("t3_href", obs_href, 18);
    cmp_data("t3");

    // 4: empty X window is rejected
    cfg_set(5, 5, 0, 6, 0, 0);
    cfg_pulse();
    chk("t4_err", cerr, 1);
    chk("t4_pend", cpend, 0);
    run_frame(8, 6, 0, 0, -1);
    chk("t4_de", obs_de, 9);
    cfg_set(2, 6, 1, 4, 0, 0);
    cfg_pulse();
    chk("t4_err0", cerr, 0);
    chk("t4_pend1", cpend, 1);

    // 5: mid-frame write lands next frame, edge write one frame later
    cfg_set(0, 4, 0, 2, 0, 0);
    run_frame(8, 6, 0, 1, -1);
    build_exp(2, 6, 1, 4, 0, 0, 8, 6);
    chk("t5a_de", obs_de, 12);
    chk("t5a_pend", cpend, 1);
    cmp_data("t5a");
    cfg_set(0, 2, 0, 1, 0, 0);
    run_frame(8, 6, 1, 0, -1);
    build_exp(0, 4, 0, 2, 0, 0, 8, 6);
    chk("t5b_de", obs_de, 8);
    chk("t5b_pend", cpend, 1);
    cmp_data("t5b");
    run_frame(8, 6, 0, 0, -1);
    build_exp(0, 2, 0, 1, 0, 0, 8, 6);
    chk("t5c_de", obs_de, 2);
    chk("t5c_pend", cpend, 0);
    cmp_data("t5c");

    // 6: reset mid-line drops the frame and restores defaults
    run_frame(8, 6, 0, 0, 2);
    chk("t6_de", obs_de, 2);
    chk("t6_fd", obs_fd, 0);
    chk("t6_err", cerr, 0);
    run_frame(8, 6, 0, 0, -1);
    chk("t6b_de", obs_de, 48);
    chk("t6b_fd", obs_fd, 1);
    cfg_set(2, 6, 1, 4, 0, 0);
    cfg_pulse();
    run_frame(8, 6, 0, 0, -1);
    chk("t6c_de", obs_de, 12);
`ifdef IMAGE_CROP_STATS_EN
    chk("t6c_sw", st_w, 4);
    chk("t6c_sh", st_h, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
